mem_arbiter: RTL and testbench

Shares one single-port synchronous RAM (2^A_WIDTH x D_WIDTH) between two requesters: a write port fed by the UART receive path and a read port used by the display path.
- Requesters use a level req / one-cycle ack handshake.
- The arbiter serialises accesses and alternates priority round-robin on contention.
- It drives the RAM control signals directly and returns read data with a valid pulse.

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port synchronous RAM between a write requester (UART
// receive path) and a read requester (display path). Accesses are serialised
// and, when both sides request in the same idle cycle, the grant alternates
// round-robin. Read data comes back through a registered rd_data bus with a
// one-cycle rd_valid pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   wr_req     write request, level, held until wr_ack
//   wr_addr    write address
//   wr_data    write data
//   wr_ack     one-cycle pulse: the write happens this cycle
//   rd_req     read request, level, held until rd_ack
//   rd_addr    read address
//   rd_ack     one-cycle pulse: the read has been accepted by the RAM
//   rd_valid   one-cycle pulse: rd_data was updated this cycle
//   rd_data    last word read, held until the next rd_valid
//   mem_addr   RAM address
//   mem_wen    RAM write enable
//   mem_ren    RAM read enable
//   mem_wdata  RAM write data
//   mem_rdata  RAM read data, valid one cycle after mem_ren
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_req,
    input  logic [A_WIDTH-1:0] wr_addr,
    input  logic [D_WIDTH-1:0] wr_data,
    output logic               wr_ack,
    input  logic               rd_req,
    input  logic [A_WIDTH-1:0] rd_addr,
    output logic               rd_ack,
    output logic               rd_valid,
    output logic [D_WIDTH-1:0] rd_data,
    output logic [A_WIDTH-1:0] mem_addr,
    output logic               mem_wen,
    output logic               mem_ren,
    output logic [D_WIDTH-1:0] mem_wdata,
    input  logic [D_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // prio = 0 means the write side wins the next contention, 1 means read.
    logic prio;
    logic grant_wr;
    logic grant_rd;

    // Grant decode: a lone request always wins; on contention prio decides.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state == IDLE) begin
            grant_wr = wr_req && (!rd_req || !prio);
            grant_rd = rd_req && (!wr_req ||  prio);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: every busy state lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_wr) begin
                    state_next = WR;
                end else if (grant_rd) begin
                    state_next = RD;
                end
            end
            WR:      state_next = IDLE;
            RD:      state_next = RD_WAIT;
            RD_WAIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: acks and RAM enables follow the registered state, so
    // they are glitch-free and drop to 0 the cycle after a reset.
    always_comb begin
        mem_wen = (state == WR);
        wr_ack  = (state == WR);
        mem_ren = (state == RD);
        rd_ack  = (state == RD_WAIT);
    end

    // Datapath registers. The address and write data are captured at grant
    // time so the RAM sees stable values during the access cycle. prio is
    // flipped in the access cycle itself, which happens exactly once per
    // grant, so uncontested grants also hand priority to the other side.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (grant_wr) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end else if (grant_rd) begin
                mem_addr  <= rd_addr;
            end
            case (state)
                WR: prio <= 1'b1;
                RD: prio <= 1'b0;
                RD_WAIT: begin
                    rd_data  <= mem_rdata;
                    rd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed self-checking bench for mem_arbiter. Inputs change and outputs are
// sampled on the falling clock edge, half a cycle away from the active edge.
// A small behavioural RAM with one-cycle read latency sits on the mem_* bus.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int D_WIDTH = 8;
    localparam int A_WIDTH = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               wr_req;
    logic [A_WIDTH-1:0] wr_addr;
    logic [D_WIDTH-1:0] wr_data;
    logic               wr_ack;
    logic               rd_req;
    logic [A_WIDTH-1:0] rd_addr;
    logic               rd_ack;
    logic               rd_valid;
    logic [D_WIDTH-1:0] rd_data;
    logic [A_WIDTH-1:0] mem_addr;
    logic               mem_wen;
    logic               mem_ren;
    logic [D_WIDTH-1:0] mem_wdata;
    logic [D_WIDTH-1:0] mem_rdata;

    logic [D_WIDTH-1:0] ram [2**A_WIDTH];

    int tests_run    = 0;
    int tests_failed = 0;

    mem_arbiter #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ack    (rd_ack),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM, read data appears one cycle after mem_ren.
    always @(posedge clk) begin
        if (mem_wen) ram[mem_addr] <= mem_wdata;
        if (mem_ren) mem_rdata <= ram[mem_addr];
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        tick(); tick();
        tests_run++; if (mem_addr !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_mem_addr: got %h expected %h", mem_addr, 3'd0); end
        tests_run++; if (mem_wdata !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_mem_wdata: got %h expected %h", mem_wdata, 8'h00); end
        tests_run++; if (rd_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_rd_data: got %h expected %h", rd_data, 8'h00); end
        tests_run++; if ({rd_valid, wr_ack, rd_ack, mem_wen, mem_ren} !== 5'b0) begin tests_failed++; $display("[TB] FAIL reset_ctrl: got %b expected %b", {rd_valid, wr_ack, rd_ack, mem_wen, mem_ren}, 5'b0); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_write;
        wr_req = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
        tick();
        tests_run++; if ({wr_ack, mem_wen, mem_ren} !== 3'b110) begin tests_failed++; $display("[TB] FAIL wr_ack_wen: got %b expected %b", {wr_ack, mem_wen, mem_ren}, 3'b110); end
        tests_run++; if (mem_addr !== 3'd3) begin tests_failed++; $display("[TB] FAIL wr_mem_addr: got %h expected %h", mem_addr, 3'd3); end
        tests_run++; if (mem_wdata !== 8'hA5) begin tests_failed++; $display("[TB] FAIL wr_mem_wdata: got %h expected %h", mem_wdata, 8'hA5); end
        wr_req = 1'b0;
        tick();
        tests_run++; if ({wr_ack, mem_wen} !== 2'b00) begin tests_failed++; $display("[TB] FAIL wr_back_idle: got %b expected %b", {wr_ack, mem_wen}, 2'b00); end
    endtask

    task automatic test_single_read;
        rd_req = 1'b1; rd_addr = 3'd3;
        tick();
        tests_run++; if ({mem_ren, rd_ack} !== 2'b10) begin tests_failed++; $display("[TB] FAIL rd_ren: got %b expected %b", {mem_ren, rd_ack}, 2'b10); end
        tests_run++; if (mem_addr !== 3'd3) begin tests_failed++; $display("[TB] FAIL rd_mem_addr: got %h expected %h", mem_addr, 3'd3); end
        tick();
        tests_run++; if ({rd_ack, mem_ren, rd_valid} !== 3'b100) begin tests_failed++; $display("[TB] FAIL rd_ack_n2: got %b expected %b", {rd_ack, mem_ren, rd_valid}, 3'b100); end
        rd_req = 1'b0;
        tick();
        tests_run++; if ({rd_valid, rd_ack} !== 2'b10) begin tests_failed++; $display("[TB] FAIL rd_valid_n3: got %b expected %b", {rd_valid, rd_ack}, 2'b10); end
        tests_run++; if (rd_data !== 8'hA5) begin tests_failed++; $display("[TB] FAIL rd_data_n3: got %h expected %h", rd_data, 8'hA5); end
        tick();
        tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rd_valid_pulse: got %b expected %b", rd_valid, 1'b0); end
        tests_run++; if (rd_data !== 8'hA5) begin tests_failed++; $display("[TB] FAIL rd_data_hold: got %h expected %h", rd_data, 8'hA5); end
    endtask

    task automatic test_contention_from_reset;
        rst = 1'b1;
        wr_req = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C;
        rd_req = 1'b1; rd_addr = 3'd5;
        tick();
        tests_run++; if ({wr_ack, rd_ack} !== 2'b00) begin tests_failed++; $display("[TB] FAIL cont_in_reset: got %b expected %b", {wr_ack, rd_ack}, 2'b00); end
        rst = 1'b0;
        tick();
        tests_run++; if ({wr_ack, mem_ren, rd_ack} !== 3'b100) begin tests_failed++; $display("[TB] FAIL cont_write_first: got %b expected %b", {wr_ack, mem_ren, rd_ack}, 3'b100); end
        tests_run++; if ({mem_addr, mem_wdata} !== {3'd5, 8'h3C}) begin tests_failed++; $display("[TB] FAIL cont_wr_bus: got %h expected %h", {mem_addr, mem_wdata}, {3'd5, 8'h3C}); end
        wr_req = 1'b0;
        tick();
        tests_run++; if ({mem_wen, mem_ren} !== 2'b00) begin tests_failed++; $display("[TB] FAIL cont_idle_gap: got %b expected %b", {mem_wen, mem_ren}, 2'b00); end
        tick();
        tests_run++; if (mem_ren !== 1'b1) begin tests_failed++; $display("[TB] FAIL cont_rd_ren: got %b expected %b", mem_ren, 1'b1); end
        tick();
        tests_run++; if (rd_ack !== 1'b1) begin tests_failed++; $display("[TB] FAIL cont_rd_ack: got %b expected %b", rd_ack, 1'b1); end
        rd_req = 1'b0;
        tick();
        tests_run++; if ({rd_valid, rd_data} !== {1'b1, 8'h3C}) begin tests_failed++; $display("[TB] FAIL cont_rd_data: got %h expected %h", {rd_valid, rd_data}, {1'b1, 8'h3C}); end
    endtask

    // Both requests held for 12 cycles starting with write priority.
    // Expected per-cycle pulses (bit index = cycle after request):
    // wr_ack at 1,6,11; rd_ack at 4,9; rd_valid at 5,10.
    task automatic test_alternation;
        logic [12:0] exp_wr;
        logic [12:0] exp_rd;
        logic [12:0] exp_val;
        logic [1:0]  last_grant;
        exp_wr  = 13'h842;
        exp_rd  = 13'h210;
        exp_val = 13'h420;
        last_grant = 2'd0;
        wr_req = 1'b1; wr_addr = 3'd2; wr_data = 8'h5A;
        rd_req = 1'b1; rd_addr = 3'd2;
        for (int i = 1; i <= 12; i++) begin
            tick();
            tests_run++; if (wr_ack !== exp_wr[i]) begin tests_failed++; $display("[TB] FAIL alt_wr_ack[%0d]: got %b expected %b", i, wr_ack, exp_wr[i]); end
            tests_run++; if (rd_ack !== exp_rd[i]) begin tests_failed++; $display("[TB] FAIL alt_rd_ack[%0d]: got %b expected %b", i, rd_ack, exp_rd[i]); end
            tests_run++; if (rd_valid !== exp_val[i]) begin tests_failed++; $display("[TB] FAIL alt_rd_valid[%0d]: got %b expected %b", i, rd_valid, exp_val[i]); end
            if (exp_val[i]) begin
                tests_run++; if (rd_data !== 8'h5A) begin tests_failed++; $display("[TB] FAIL alt_rd_data[%0d]: got %h expected %h", i, rd_data, 8'h5A); end
            end
            if (wr_ack === 1'b1 || rd_ack === 1'b1) begin
                tests_run++; if ({1'b0, rd_ack} + 2'd1 === last_grant) begin tests_failed++; $display("[TB] FAIL alt_repeat[%0d]: got side %0d expected side != %0d", i, {1'b0, rd_ack} + 2'd1, last_grant); end
                last_grant = {1'b0, rd_ack} + 2'd1;
            end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_ack;
        exp_ack = 4'b0101;
        wr_req = 1'b1; wr_addr = 3'd7; wr_data = 8'hE1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++; if (wr_ack !== exp_ack[i]) begin tests_failed++; $display("[TB] FAIL b2b_wr_ack[%0d]: got %b expected %b", i, wr_ack, exp_ack[i]); end
        end
        wr_req = 1'b0;
        tick();
    endtask

    // Last grant was a lone write, so the read must win this contention.
    task automatic test_prio_after_write;
        wr_req = 1'b1; wr_addr = 3'd1; wr_data = 8'h22;
        rd_req = 1'b1; rd_addr = 3'd2;
        tick();
        tests_run++; if ({mem_ren, wr_ack} !== 2'b10) begin tests_failed++; $display("[TB] FAIL prio_read_wins: got %b expected %b", {mem_ren, wr_ack}, 2'b10); end
        tick();
        rd_req = 1'b0;
        tick();
        tests_run++; if ({rd_valid, rd_data} !== {1'b1, 8'h5A}) begin tests_failed++; $display("[TB] FAIL prio_rd_data: got %h expected %h", {rd_valid, rd_data}, {1'b1, 8'h5A}); end
        tick();
        tests_run++; if ({wr_ack, mem_addr, mem_wdata} !== {1'b1, 3'd1, 8'h22}) begin tests_failed++; $display("[TB] FAIL prio_wr_after_valid: got %h expected %h", {wr_ack, mem_addr, mem_wdata}, {1'b1, 3'd1, 8'h22}); end
        wr_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_read;
        rd_req = 1'b1; rd_addr = 3'd7;
        tick(); tick();
        tests_run++; if (rd_ack !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_mid_in_wait: got %b expected %b", rd_ack, 1'b1); end
        rst = 1'b1; rd_req = 1'b0;
        tick();
        tests_run++; if ({rd_valid, rd_ack, wr_ack, mem_wen, mem_ren} !== 5'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_ctrl: got %b expected %b", {rd_valid, rd_ack, wr_ack, mem_wen, mem_ren}, 5'b0); end
        tests_run++; if ({rd_data, mem_addr, mem_wdata} !== 19'h0) begin tests_failed++; $display("[TB] FAIL rst_mid_buses: got %h expected %h", {rd_data, mem_addr, mem_wdata}, 19'h0); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if ({rd_valid, rd_data} !== 9'h0) begin tests_failed++; $display("[TB] FAIL rst_mid_no_valid[%0d]: got %h expected %h", i, {rd_valid, rd_data}, 9'h0); end
        end
    endtask

    // A lone write leaves read priority; reset must restore write priority.
    task automatic test_reset_prio;
        wr_req = 1'b1; wr_addr = 3'd4; wr_data = 8'h99;
        tick();
        wr_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr_req = 1'b1; wr_addr = 3'd4; wr_data = 8'h66;
        rd_req = 1'b1; rd_addr = 3'd4;
        tick();
        tests_run++; if ({wr_ack, mem_ren} !== 2'b10) begin tests_failed++; $display("[TB] FAIL rst_prio_write_first: got %b expected %b", {wr_ack, mem_ren}, 2'b10); end
        wr_req = 1'b0;
        tick(); tick(); tick();
        rd_req = 1'b0;
        tick();
        tests_run++; if ({rd_valid, rd_data} !== {1'b1, 8'h66}) begin tests_failed++; $display("[TB] FAIL rst_prio_raw: got %h expected %h", {rd_valid, rd_data}, {1'b1, 8'h66}); end
    endtask

    task automatic test_idle_hold;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests_run++; if ({mem_wen, mem_ren, wr_ack, rd_ack, rd_valid} !== 5'b0) begin tests_failed++; $display("[TB] FAIL idle_ctrl[%0d]: got %b expected %b", i, {mem_wen, mem_ren, wr_ack, rd_ack, rd_valid}, 5'b0); end
            tests_run++; if ({mem_addr, mem_wdata} !== {3'd4, 8'h66}) begin tests_failed++; $display("[TB] FAIL idle_hold[%0d]: got %h expected %h", i, {mem_addr, mem_wdata}, {3'd4, 8'h66}); end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention_from_reset();
        test_alternation();
        test_back_to_back();
        test_prio_after_write();
        test_reset_mid_read();
        test_reset_prio();
        test_idle_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
